// File: rtl/sap_pkg.sv
// Shared constants for the SAP controller: opcodes, T-state indices and
// control-word bit positions.
package sap_pkg;

    localparam int NUM_T = 6;
    localparam int OP_W  = 4;

    typedef enum logic [OP_W-1:0] {
        OP_LDA = 4'h0,
        OP_ADD = 4'h1,
        OP_SUB = 4'h2,
        OP_OUT = 4'h3,
        OP_HLT = 4'h4
    } opcode_e;

    // Bit index of each T-state inside the one-hot ring (bit0 = T1).
    localparam int T1 = 0;
    localparam int T2 = 1;
    localparam int T3 = 2;
    localparam int T4 = 3;
    localparam int T5 = 4;
    localparam int T6 = 5;

    localparam int CW_CP   = 0;
    localparam int CW_EP   = 1;
    localparam int CW_LM_N = 2;
    localparam int CW_CE_N = 3;
    localparam int CW_LI_N = 4;
    localparam int CW_EI_N = 5;
    localparam int CW_LA_N = 6;
    localparam int CW_EA   = 7;
    localparam int CW_SU   = 8;
    localparam int CW_EU   = 9;
    localparam int CW_LB_N = 10;
    localparam int CW_LO_N = 11;
    localparam int CW_W    = 12;

    typedef logic [CW_W-1:0] ctrl_word_t;

    // Every control at its inactive level: active-low strobes high, the rest low.
    localparam ctrl_word_t CW_IDLE =
        (ctrl_word_t'(1) << CW_LM_N) | (ctrl_word_t'(1) << CW_CE_N) |
        (ctrl_word_t'(1) << CW_LI_N) | (ctrl_word_t'(1) << CW_EI_N) |
        (ctrl_word_t'(1) << CW_LA_N) | (ctrl_word_t'(1) << CW_LB_N) |
        (ctrl_word_t'(1) << CW_LO_N);

    function automatic logic is_defined_op(input logic [OP_W-1:0] op);
        return op <= OP_W'(OP_HLT);
    endfunction

endpackage

// File: rtl/sap_ring_counter.sv
// One-hot T-state ring counter; rotates one position per clock unless held.
module sap_ring_counter #(
    parameter int NUM_T = sap_pkg::NUM_T
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic             hold,
    output logic [NUM_T-1:0] T
);

    always_ff @(posedge CLK) begin
        if (CLR) begin
            T <= NUM_T'(1);
        end else if (!hold) begin
            T <= {T[NUM_T-2:0], T[NUM_T-1]};
        end
    end

endmodule

// File: rtl/sap_controller_sequencer.sv
// SAP fetch/execute controller: ring counter plus opcode decode into the control word.
// Optional build macro SAP_ILLEGAL_HALT_EN traps undefined opcodes as a halt.
module sap_controller_sequencer #(
    parameter int NUM_T = sap_pkg::NUM_T,
    parameter int OP_W  = sap_pkg::OP_W
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [OP_W-1:0]  Opcode,
    output logic [NUM_T-1:0] T,
    output logic             Cp,
    output logic             Ep,
    output logic             Lm_n,
    output logic             CE_n,
    output logic             Li_n,
    output logic             Ei_n,
    output logic             La_n,
    output logic             Ea,
    output logic             Su,
    output logic             Eu,
    output logic             Lb_n,
    output logic             Lo_n,
    output logic             Halted,
    output logic             IllegalOp
);

    import sap_pkg::*;

    logic [NUM_T-1:0] t_state;
    logic             halted;
    logic             halt_now;
    logic             illegal_now;
    ctrl_word_t       cw;

    // Holding on halt_now keeps the counter parked at T4 on the halting edge.
    sap_ring_counter #(
        .NUM_T (NUM_T)
    ) u_ring (
        .CLK  (CLK),
        .CLR  (CLR),
        .hold (halted | halt_now),
        .T    (t_state)
    );

    always_comb begin
        illegal_now = 1'b0;
`ifdef SAP_ILLEGAL_HALT_EN
        illegal_now = t_state[T4] && !halted && !is_defined_op(Opcode);
`endif
        halt_now = t_state[T4] && !halted &&
                   ((Opcode == OP_W'(OP_HLT)) || illegal_now);
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            halted <= 1'b0;
        end else if (halt_now) begin
            halted <= 1'b1;
        end
    end

`ifdef SAP_ILLEGAL_HALT_EN
    logic illegal_op;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            illegal_op <= 1'b0;
        end else if (illegal_now) begin
            illegal_op <= 1'b1;
        end
    end

    assign IllegalOp = illegal_op;
`else
    assign IllegalOp = 1'b0;
`endif

    // Fetch is opcode-independent; execute looks at Opcode only in T4..T6.
    always_comb begin
        cw = CW_IDLE;
        if (!halted) begin
            if (t_state[T1]) begin
                cw[CW_EP]   = 1'b1;
                cw[CW_LM_N] = 1'b0;
            end
            if (t_state[T2]) begin
                cw[CW_CP] = 1'b1;
            end
            if (t_state[T3]) begin
                cw[CW_CE_N] = 1'b0;
                cw[CW_LI_N] = 1'b0;
            end
            if (t_state[T4]) begin
                case (Opcode)
                    OP_W'(OP_LDA), OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        cw[CW_EI_N] = 1'b0;
                        cw[CW_LM_N] = 1'b0;
                    end
                    OP_W'(OP_OUT): begin
                        cw[CW_EA]   = 1'b1;
                        cw[CW_LO_N] = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (t_state[T5]) begin
                case (Opcode)
                    OP_W'(OP_LDA): begin
                        cw[CW_CE_N] = 1'b0;
                        cw[CW_LA_N] = 1'b0;
                    end
                    OP_W'(OP_ADD), OP_W'(OP_SUB): begin
                        cw[CW_CE_N] = 1'b0;
                        cw[CW_LB_N] = 1'b0;
                    end
                    default: ;
                endcase
            end
            if (t_state[T6]) begin
                if (Opcode == OP_W'(OP_ADD) || Opcode == OP_W'(OP_SUB)) begin
                    cw[CW_EU]   = 1'b1;
                    cw[CW_LA_N] = 1'b0;
                    cw[CW_SU]   = (Opcode == OP_W'(OP_SUB));
                end
            end
        end
    end

    assign T      = t_state;
    assign Halted = halted;
    assign Cp     = cw[CW_CP];
    assign Ep     = cw[CW_EP];
    assign Lm_n   = cw[CW_LM_N];
    assign CE_n   = cw[CW_CE_N];
    assign Li_n   = cw[CW_LI_N];
    assign Ei_n   = cw[CW_EI_N];
    assign La_n   = cw[CW_LA_N];
    assign Ea     = cw[CW_EA];
    assign Su     = cw[CW_SU];
    assign Eu     = cw[CW_EU];
    assign Lb_n   = cw[CW_LB_N];
    assign Lo_n   = cw[CW_LO_N];

endmodule

// File: tb/tb_sap_controller_sequencer.sv
// Bench for sap_controller_sequencer: vector table, directed sequences and a
// randomized run against an instruction-level model of the SAP controller.
module tb_sap_controller_sequencer;

    logic       CLK = 1'b0;
    logic       CLR = 1'b1;
    logic [3:0] Opcode = 4'h0;
    logic [5:0] T;
    logic Cp, Ep, Lm_n, CE_n, Li_n, Ei_n, La_n, Ea, Su, Eu, Lb_n, Lo_n;
    logic Halted, IllegalOp;

    int total = 0;
    int bad   = 0;

    // Asserted-control masks (1 = strobe active regardless of pin polarity).
    localparam logic [11:0] M_CP = 12'h800, M_EP = 12'h400, M_LM = 12'h200,
                            M_CE = 12'h100, M_LI = 12'h080, M_EI = 12'h040,
                            M_LA = 12'h020, M_EA = 12'h010, M_SU = 12'h008,
                            M_EU = 12'h004, M_LB = 12'h002, M_LO = 12'h001;
`ifdef SAP_ILLEGAL_HALT_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    sap_controller_sequencer dut (
        .CLK(CLK), .CLR(CLR), .Opcode(Opcode), .T(T),
        .Cp(Cp), .Ep(Ep), .Lm_n(Lm_n), .CE_n(CE_n), .Li_n(Li_n), .Ei_n(Ei_n),
        .La_n(La_n), .Ea(Ea), .Su(Su), .Eu(Eu), .Lb_n(Lb_n), .Lo_n(Lo_n),
        .Halted(Halted), .IllegalOp(IllegalOp)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  op;
        int          t;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[14];

    // Model state: T-state number 1..6 and the sticky halt flags.
    int m_t    = 1;
    bit m_halt = 1'b0;
    bit m_ill  = 1'b0;

    function automatic logic [11:0] observed();
        return {Cp, Ep, ~Lm_n, ~CE_n, ~Li_n, ~Ei_n, ~La_n, Ea, Su, Eu, ~Lb_n, ~Lo_n};
    endfunction

    // Micro-program of the SAP instruction set, written from the instruction table.
    function automatic logic [11:0] spec_ctl(input int t, input logic [3:0] op);
        logic is_alu;
        is_alu = (op == 4'd1) || (op == 4'd2);
        case (t)
            1: return M_EP | M_LM;
            2: return M_CP;
            3: return M_CE | M_LI;
            4: if (op == 4'd0 || is_alu) return M_EI | M_LM;
               else if (op == 4'd3) return M_EA | M_LO;
               else return 12'h000;
            5: if (op == 4'd0) return M_CE | M_LA;
               else if (is_alu) return M_CE | M_LB;
               else return 12'h000;
            6: if (op == 4'd1) return M_EU | M_LA;
               else if (op == 4'd2) return M_EU | M_LA | M_SU;
               else return 12'h000;
            default: return 12'h000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic check_bus(input string name);
        int drivers;
        drivers = int'(Ep) + int'(Ea) + int'(Eu) + int'(!CE_n) + int'(!Ei_n);
        total++;
        if (drivers > 1) begin
            bad++;
            $display("FAIL %s_bus actual=%0d drivers required<=1", name, drivers);
        end
    endtask

    task automatic hard_reset();
        CLR = 1'b1;
        Opcode = 4'h0;
        @(posedge CLK); #1;
        m_t = 1;
        m_halt = 1'b0;
        m_ill = 1'b0;
    endtask

    // One clock: drive, compare outputs against the model, then advance both.
    task automatic cycle(input string name, input logic clr, input logic [3:0] op);
        logic [11:0] exp_ctl;
        CLR = clr;
        Opcode = op;
        #1;
        exp_ctl = m_halt ? 12'h000 : spec_ctl(m_t, op);
        check(name, {12'h0, T, Halted, IllegalOp, observed()},
              {12'h0, 6'(1 << (m_t - 1)), m_halt, m_ill, exp_ctl});
        check_bus(name);
        if (clr) begin
            m_t = 1;
            m_halt = 1'b0;
            m_ill = 1'b0;
        end else if (!m_halt) begin
            if (m_t == 4 && op == 4'd4) begin
                m_halt = 1'b1;
            end else if (m_t == 4 && ILL_EN && op > 4'd4) begin
                m_halt = 1'b1;
                m_ill = 1'b1;
            end else begin
                m_t = (m_t % 6) + 1;
            end
        end
        @(posedge CLK); #1;
    endtask

    initial begin
        vecs = '{
            '{4'h0, 1, M_EP | M_LM},
            '{4'h0, 2, M_CP},
            '{4'h0, 3, M_CE | M_LI},
            '{4'h0, 4, M_EI | M_LM},
            '{4'h0, 5, M_CE | M_LA},
            '{4'h0, 6, 12'h000},
            '{4'h1, 5, M_CE | M_LB},
            '{4'h1, 6, M_EU | M_LA},
            '{4'h2, 4, M_EI | M_LM},
            '{4'h2, 6, M_EU | M_LA | M_SU},
            '{4'h3, 4, M_EA | M_LO},
            '{4'h3, 5, 12'h000},
            '{4'h4, 4, 12'h000},
            '{4'hA, 4, 12'h000}
        };

        for (int i = 0; i < 14; i++) begin
            hard_reset();
            CLR = 1'b0;
            Opcode = vecs[i].op;
            for (int k = 1; k < vecs[i].t; k++) begin
                @(posedge CLK); #1;
            end
            #1;
            check($sformatf("vec%0d", i), {20'h0, observed()}, {20'h0, vecs[i].exp});
            check($sformatf("vec%0d_t", i), {26'h0, T}, {26'h0, 6'(1 << (vecs[i].t - 1))});
        end

        // Reset held two cycles, then the first fetch steps.
        hard_reset();
        cycle("rst_a", 1'b1, 4'h0);
        cycle("rst_b", 1'b1, 4'h0);
        cycle("fetch_t1", 1'b0, 4'h0);
        cycle("fetch_t2", 1'b0, 4'h0);
        for (int k = 0; k < 4; k++) cycle("lda_rest", 1'b0, 4'h0);

        // Program LDA, ADD, SUB, OUT, HLT followed by a long halted stretch.
        for (int p = 0; p < 4; p++) begin
            for (int k = 0; k < 6; k++) cycle($sformatf("prog%0d", p), 1'b0, 4'(p));
        end
        for (int k = 0; k < 4; k++) cycle("prog_hlt", 1'b0, 4'h4);
        for (int k = 0; k < 20; k++) cycle("halted", 1'b0, 4'($urandom_range(0, 15)));

        // Reset in the middle of ADD T5, then a clean LDA.
        hard_reset();
        cycle("clr_mid_a", 1'b1, 4'h0);
        for (int k = 0; k < 4; k++) cycle("add_pre", 1'b0, 4'h1);
        cycle("clr_add_t5", 1'b1, 4'h1);
        for (int k = 0; k < 6; k++) cycle("post_clr", 1'b0, 4'h0);

        // Undefined opcode 1010 through a whole instruction window.
        hard_reset();
        cycle("ill_rst", 1'b1, 4'h0);
        for (int k = 0; k < 10; k++) cycle("op_1010", 1'b0, 4'hA);
        cycle("ill_clr", 1'b1, 4'hA);
        cycle("ill_after", 1'b0, 4'h0);

        // Randomized opcode stream with occasional resets.
        for (int k = 0; k < 800; k++) begin
            cycle("rand", ($urandom_range(0, 24) == 0), 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sap_controller_sequencer.md
Name: sap_controller_sequencer

Overview:
Fetch/execute controller for the 8-bit SAP processor. A one-hot ring counter steps six T-states per instruction. The 4-bit opcode from the instruction register is decoded into the control word for PC, MAR, RAM, IR, accumulator, ALU, B and output registers. It drives the RAM's active-low CE and halts the machine on HLT.

Parameters:
NUM_T, 6, T-states per instruction; fixed at 6, present for package consistency.
OP_W, 4, opcode width (upper nibble of IR).

Ports:
CLK  input  1  system clock, all state updates on rising edge
CLR  input  1  synchronous active-high reset
Opcode  input  OP_W  instruction-register upper nibble
T  output  NUM_T  one-hot T-state (bit0 = T1)
Cp  output  1  PC increment enable
Ep  output  1  PC drive onto W bus
Lm_n  output  1  MAR load, active low
CE_n  output  1  RAM drive onto W bus, active low (RAM CE)
Li_n  output  1  IR load, active low
Ei_n  output  1  IR low nibble onto W bus, active low
La_n  output  1  accumulator load, active low
Ea  output  1  accumulator drive onto W bus
Su  output  1  ALU subtract (1) / add (0)
Eu  output  1  ALU drive onto W bus
Lb_n  output  1  B register load, active low
Lo_n  output  1  output register load, active low
Halted  output  1  machine halted
IllegalOp  output  1  undefined opcode trapped (see Optional Feature)

Behaviour:
- Reset (CLR=1 at an edge): T=6'b000001, Halted=0, IllegalOp=0. Takes effect the same cycle from any state, including mid-instruction or halted.
- All control outputs decode combinationally from the registered T and Halted plus Opcode. Inactive levels: active-high outputs 0, _n outputs 1. The datapath loads on the rising edge that ends the T-state.
- Ring counter: T1→T2→…→T6→T1, one step per clock while Halted=0.
- Fetch, all opcodes:
  - T1: Ep=1, Lm_n=0.
  - T2: Cp=1.
  - T3: CE_n=0, Li_n=0.
- Execute:
  - LDA (0000):
    - T4: Ei_n=0, Lm_n=0.
    - T5: CE_n=0, La_n=0.
    - T6: none.
  - ADD (0001):
    - T4: Ei_n=0, Lm_n=0.
    - T5: CE_n=0, Lb_n=0.
    - T6: Eu=1, La_n=0, Su=0.
  - SUB (0010): same as ADD, but Su=1 during T6.
  - OUT (0011):
    - T4: Ea=1, Lo_n=0.
    - T5, T6: none.
  - HLT (0100): in T4, Halted is set at the end of the cycle. Counter freezes at T4, and all controls stay inactive while halted.
  - Opcodes 0101–1111: NOP for T4–T6, unless the optional feature is enabled.
- Bus exclusivity: at most one of Ep, Ea, Eu, ~CE_n, ~Ei_n is active in any state. Must hold for every opcode.
- Opcode is sampled only in T4–T6. It is don't-care in T1–T3 because the IR loads at the end of T3.
- Halted exits only through CLR.

Optional Feature:
Macro SAP_ILLEGAL_HALT_EN.
- Defined: an undefined opcode in T4 sets Halted=1 and IllegalOp=1 at the end of T4, freezing like HLT. Both clear only on CLR.
- Undefined: undefined opcodes execute as NOPs, and IllegalOp is tied to 0.

Decomposition:
- Package sap_pkg:
  - opcode constants OP_LDA, OP_ADD, OP_SUB, OP_OUT, OP_HLT
  - T-state index constants T1..T6
  - control-word bit-position constants, plus an inactive-control-word constant
- Sub-module sap_ring_counter: one-hot counter with CLK, CLR and a hold input driven by Halted.
- Decode stays in sap_controller_sequencer.

Test Plan:
- CLR=1 for 2 cycles, then release → T=000001, Halted=0, Ep=1, Lm_n=0 in the first cycle. Next cycle T=000010, Cp=1.
- Opcode=0000 (LDA) over 6 clocks → T4: Ei_n=0, Lm_n=0. T5: CE_n=0, La_n=0. T6: all inactive. Back to T1.
- Opcode=0010 (SUB) → T5: Lb_n=0, CE_n=0. T6: Eu=1, Su=1, La_n=0. Repeat with 0001 (ADD) → Su=0 in T6.
- Program sequence 0,1,2,3,4 (LDA/ADD/SUB/OUT/HLT) → OUT T4 has Ea=1, Lo_n=0. HLT sets Halted=1 after T4. T stays 001000 for 20 further clocks with all controls inactive.
- CLR asserted during ADD T5 → next edge T=000001. A following fetch is correct.
- Opcode=1010 in T4:
  - With SAP_ILLEGAL_HALT_EN → Halted=1, IllegalOp=1.
  - Without it → NOP and return to T1.
  - Every cycle in both cases: bus-exclusivity assertion holds.
